// File: rtl/spi_bus_monitor.sv
// spi_bus_monitor: passive SPI link decoder producing one record per transaction plus error counters
module spi_bus_monitor #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MEM_DEPTH = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  input  logic              miso,
  input  logic              ready,
  output logic              txn_valid,
  output logic              txn_wr,
  output logic [ADDR_W-1:0] txn_addr,
  output logic [DATA_W-1:0] txn_data,
  output logic              txn_err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int FW = ADDR_W + DATA_W;
  localparam int MX = TIMEOUT > FW ? TIMEOUT : FW;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] AW_C = CW'(ADDR_W);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] F_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH = MEM_DEPTH[ADDR_W:0];
  typedef enum logic [2:0] {IDLE, OP, WR_SHIFT, RD_ADDR, RD_WAIT, RD_DATA, REPORT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] data, data_n;
  logic op, op_n, pend, pend_n, armed, cs_q;
  logic [1:0] code, code_n, rep_code;
  logic ok_rec;
  assign rep_code = (code == 2'd0 && {1'b0, addr} >= DEPTH) ? 2'd3 : code;
  assign ok_rec = pend && rep_code == 2'd0;
  // next-state and field capture; a report is staged in pend and published on the following edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr;
    data_n = data;
    op_n = op;
    code_n = code;
    pend_n = 1'b0;
    case (state)
      IDLE: state_n = (!cs && armed) ? OP : IDLE;
      OP: begin
        op_n = mosi;
        addr_n = '0;
        data_n = '0;
        cnt_n = '0;
        code_n = 2'd0;
        state_n = mosi ? WR_SHIFT : RD_ADDR;
      end
      WR_SHIFT, RD_ADDR: begin
        if (cs) begin
          state_n = REPORT;
          pend_n = 1'b1;
          code_n = 2'd1;
        end else begin
          if (cnt < AW_C) addr_n = addr | (ADDR_W'(mosi) << cnt);
          else data_n = data | (DATA_W'(mosi) << (cnt - AW_C));
          cnt_n = cnt + 1'b1;
          if (state == RD_ADDR && cnt == A_LAST) begin
            state_n = RD_WAIT;
            cnt_n = '0;
          end
          if (state == WR_SHIFT && cnt == F_LAST) begin
            state_n = REPORT;
            pend_n = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (cs_q && !cs) begin
          state_n = OP;
          pend_n = 1'b1;
          code_n = 2'd2;
        end else if (ready) begin
          state_n = RD_DATA;
          cnt_n = '0;
        end else if (cnt == T_LAST) begin
          state_n = REPORT;
          pend_n = 1'b1;
          code_n = 2'd2;
        end else cnt_n = cnt + 1'b1;
      end
      RD_DATA: begin
        data_n = data | (DATA_W'(miso) << cnt);
        cnt_n = cnt + 1'b1;
        if (cnt == D_LAST) begin
          state_n = REPORT;
          pend_n = 1'b1;
        end
      end
      REPORT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, capture registers, published record and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      data <= '0;
      op <= 1'b0;
      code <= '0;
      pend <= 1'b0;
      armed <= 1'b0;
      cs_q <= 1'b0;
      txn_valid <= 1'b0;
      txn_wr <= 1'b0;
      txn_addr <= '0;
      txn_data <= '0;
      txn_err <= 1'b0;
      err_code <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr <= addr_n;
      data <= data_n;
      op <= op_n;
      code <= code_n;
      pend <= pend_n;
      armed <= cs | (armed & (state_n != OP));
      cs_q <= cs;
      txn_valid <= pend;
      if (pend) begin
        txn_wr <= op;
        txn_addr <= addr;
        txn_data <= data;
        err_code <= rep_code;
        txn_err <= rep_code != 2'd0;
      end
      wr_cnt <= wr_cnt + CNT_W'(ok_rec && op && wr_cnt != '1);
      rd_cnt <= rd_cnt + CNT_W'(ok_rec && !op && rd_cnt != '1);
      err_cnt <= err_cnt + CNT_W'(pend && rep_code != 2'd0 && err_cnt != '1);
    end
  end
endmodule

// File: tb/tb_spi_bus_monitor.sv
// tb_spi_bus_monitor: scoreboard bench driving SPI frames and checking decoded records, latency and counters
module tb_spi_bus_monitor;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso = 1'b0;
  logic ready = 1'b0;
  logic txn_valid, txn_wr, txn_err;
  logic [7:0] txn_addr, txn_data;
  logic [1:0] err_code;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
  logic s_valid, s_wr, s_err;
  logic [7:0] s_addr, s_data;
  logic [1:0] s_code;
  logic [1:0] s_wr_cnt, s_rd_cnt, s_err_cnt;
  typedef struct {
    logic wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
    int due;
  } rec_t;
  rec_t q[$];
  rec_t e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int mwr, mrd, merr, swr, srd, serr;
  logic [8:0] f;
  spi_bus_monitor dut (
    .clk(clk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso), .ready(ready),
    .txn_valid(txn_valid), .txn_wr(txn_wr), .txn_addr(txn_addr), .txn_data(txn_data),
    .txn_err(txn_err), .err_code(err_code), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
  );
  spi_bus_monitor #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso), .ready(ready),
    .txn_valid(s_valid), .txn_wr(s_wr), .txn_addr(s_addr), .txn_data(s_data),
    .txn_err(s_err), .err_code(s_code), .wr_cnt(s_wr_cnt), .rd_cnt(s_rd_cnt), .err_cnt(s_err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick(input logic c, input logic m, input logic s, input logic r);
    @(posedge clk);
    #1;
    cs = c;
    mosi = m;
    miso = s;
    ready = r;
  endtask
  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d, input int nb, input int extra, input bit started);
    logic [16:0] fb;
    logic [15:0] m;
    int e0;
    fb = {d, a, 1'b1};
    if (!started) tick(1'b0, 1'b0, 1'b0, 1'b0);
    e0 = cyc + 1;
    m = {d, a} & 16'((32'd1 << (nb - 1)) - 32'd1);
    if (nb >= 17) q.push_back('{1'b1, a, d, (int'(a) >= DEPTH) ? 2'd3 : 2'd0, e0 + 18});
    else q.push_back('{1'b1, m[7:0], m[15:8], 2'd1, e0 + nb + 2});
    for (int i = 0; i < nb; i++) tick(1'b0, fb[i], 1'b0, 1'b0);
    repeat (extra) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rd_frame(input logic [7:0] a, input logic [7:0] d, input int w);
    logic [8:0] fb;
    int e0;
    int r;
    fb = {a, 1'b0};
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    e0 = cyc + 1;
    if (w == -2) begin
      q.push_back('{1'b0, a & 8'h0F, 8'h00, 2'd1, e0 + 7});
      for (int i = 0; i < 5; i++) tick(1'b0, fb[i], 1'b0, 1'b0);
      repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int i = 0; i < 9; i++) tick(1'b0, fb[i], 1'b0, 1'b0);
    if (w < 0) begin
      q.push_back('{1'b0, a, 8'h00, 2'd2, e0 + 74});
      repeat (64) tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end else begin
      repeat (w) tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      r = cyc + 1;
      q.push_back('{1'b0, a, d, (int'(a) >= DEPTH) ? 2'd3 : 2'd0, r + 9});
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, d[i], 1'b0);
    end
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      mwr = 0; mrd = 0; merr = 0; swr = 0; srd = 0; serr = 0;
    end else if (txn_valid) begin
      if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("txn_wr", txn_wr, e.wr);
        check("txn_addr", txn_addr, e.addr);
        check("txn_data", txn_data, e.data);
        check("err_code", err_code, e.code);
        check("txn_err", txn_err, e.code != 2'd0);
        if (e.code != 2'd0) begin
          merr = merr < 65535 ? merr + 1 : merr;
          serr = serr < 3 ? serr + 1 : serr;
        end else if (e.wr) begin
          mwr = mwr < 65535 ? mwr + 1 : mwr;
          swr = swr < 3 ? swr + 1 : swr;
        end else begin
          mrd = mrd < 65535 ? mrd + 1 : mrd;
          srd = srd < 3 ? srd + 1 : srd;
        end
        check("wr_cnt", wr_cnt, mwr);
        check("rd_cnt", rd_cnt, mrd);
        check("err_cnt", err_cnt, merr);
        check("sat_valid", s_valid, 1'b1);
        check("sat_code", s_code, e.code);
        check("sat_wr_cnt", s_wr_cnt, swr);
        check("sat_rd_cnt", s_rd_cnt, srd);
        check("sat_err_cnt", s_err_cnt, serr);
      end
    end else if (q.size() != 0 && cyc > q[0].due) begin
      check("missing_valid", 32'd0, 32'd1);
      void'(q.pop_front());
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", txn_valid, 1'b0);
    check("rst_wr", txn_wr, 1'b0);
    check("rst_addr", txn_addr, 8'h00);
    check("rst_data", txn_data, 8'h00);
    check("rst_err", {txn_err, err_code}, 3'b000);
    check("rst_cnts", {wr_cnt, rd_cnt, err_cnt}, 48'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    wr_frame(8'h05, 8'hA5, 17, 0, 1'b0);
    wr_frame(8'h0A, 8'h3C, 17, 5, 1'b0);
    rd_frame(8'h1F, 8'h3C, 3);
    wr_frame(8'h04, 8'hFF, 10, 0, 1'b0);
    wr_frame(8'h1B, 8'h66, 5, 0, 1'b0);
    rd_frame(8'h1D, 8'h00, -2);
    rd_frame(8'h03, 8'h00, -1);
    rd_frame(8'h10, 8'h81, 63);
    wr_frame(8'h28, 8'h77, 17, 0, 1'b0);
    rd_frame(8'h28, 8'hC3, 2);
    rd_frame(8'h30, 8'h00, -1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    f = {8'h07, 1'b0};
    for (int i = 0; i < 9; i++) tick(1'b0, f[i], 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    q.push_back('{1'b0, 8'h07, 8'h00, 2'd2, cyc + 2});
    wr_frame(8'h09, 8'h5A, 17, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) wr_frame(8'($urandom_range(0, 31)), 8'($urandom), 17, 0, 1'b0);
      else rd_frame(8'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 10));
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain_before_rst", q.size(), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    f = {8'h02, 1'b1};
    for (int i = 0; i < 8; i++) tick(1'b0, f[i], 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_wr_cnt", wr_cnt, 16'h0);
    check("midrst_err_cnt", err_cnt, 16'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    wr_frame(8'h02, 8'h11, 17, 0, 1'b0);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain_final", q.size(), 0);
    repeat (5) @(negedge clk);
    check("final_wr_cnt", wr_cnt, 16'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
